// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared constants, receiver state type and parity helper for the
//             PS/2 keyboard key encoder.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_rx
//  Purpose  : PS/2 line receiver. Synchronises clock and data, glitch-filters
//             the clock, deserialises 11-bit frames and reports a byte-valid
//             or error pulse per frame. Stalled frames are aborted by timeout.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam logic [c_FW-1:0] c_FLT_MAX = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_MAX  = c_TW'(TIMEOUT - 1);

    logic            r_clk_meta, r_clk_sync;
    logic            r_data_meta, r_data_sync;
    logic [c_FW-1:0] r_flt_cnt;
    logic            r_clk_filt, r_clk_filt_d;
    logic            w_fall;

    ps2_rx_state_t   r_state, w_state_nx;
    logic [3:0]      r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic            r_par, w_par_nx;
    logic [c_TW-1:0] r_to_cnt, w_to_nx;
    logic            r_valid, w_valid_nx;
    logic            r_err, w_err_nx;

    // Two-flop synchronisers; the idle PS/2 bus level is high.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= i_ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= i_ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    // Filtered clock follows the synced clock only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_flt_cnt    <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FLT_MAX) begin
                r_clk_filt <= r_clk_sync;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // Receiver state and datapath registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_par     <= w_par_nx;
            r_to_cnt  <= w_to_nx;
            r_valid   <= w_valid_nx;
            r_err     <= w_err_nx;
        end
    end

    // Next-state logic: an edge always takes precedence over the timeout.
    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_par_nx     = r_par;
        w_to_nx      = r_to_cnt;
        w_valid_nx   = 1'b0;
        w_err_nx     = 1'b0;
        if (r_state == IDLE) begin
            w_to_nx = '0;
            if (w_fall && !r_data_sync) begin
                w_state_nx   = DATA;
                w_bit_cnt_nx = 4'd1;
            end
        end else if (w_fall) begin
            w_to_nx = '0;
            case (r_state)
                DATA: begin
                    w_shift_nx   = {r_data_sync, r_shift[7:1]};
                    w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd8) begin
                        w_state_nx = PARITY;
                    end
                end
                PARITY: begin
                    w_par_nx     = r_data_sync;
                    w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    w_state_nx   = STOP;
                end
                STOP: begin
                    w_state_nx   = IDLE;
                    w_bit_cnt_nx = '0;
                    if (ps2_parity_ok(r_shift, r_par) && r_data_sync) begin
                        w_valid_nx = 1'b1;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
                default: begin
                    w_state_nx   = IDLE;
                    w_bit_cnt_nx = '0;
                end
            endcase
        end else if (r_to_cnt == c_TO_MAX) begin
            w_state_nx   = IDLE;
            w_bit_cnt_nx = '0;
            w_to_nx      = '0;
            w_err_nx     = 1'b1;
        end else begin
            w_to_nx = r_to_cnt + 1'b1;
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_valid;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_encoder
//  Purpose  : Converts a raw PS/2 keyboard line into the 11-bit ps2_key event
//             word {toggle, pressed, extended, code}, stripping E0/F0 prefixes
//             and swallowing the Pause (E1) sequence.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        frame_err
);

    logic [7:0]  w_rx_byte;
    logic        w_rx_valid;
    logic        w_rx_err;

    logic        r_ext;
    logic        r_brk;
    logic [2:0]  r_skip;
    logic [10:0] r_key;
    logic        r_strobe;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame_rx (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid),
        .o_err        (w_rx_err)
    );

    // Prefix/skip assembler: pending Pause bytes are swallowed before any prefix decoding.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_skip   <= '0;
            r_key    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_rx_err) begin
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
                r_skip <= '0;
            end else if (w_rx_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else if (w_rx_byte == PS2_PFX_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_rx_byte == PS2_PFX_BRK) begin
                    r_brk <= 1'b1;
                end else if (w_rx_byte == PS2_PFX_PAUSE) begin
                    r_skip <= PS2_PAUSE_SKIP;
                end else begin
                    r_key    <= {~r_key[10], ~r_brk, r_ext, w_rx_byte};
                    r_strobe <= 1'b1;
                    r_ext    <= 1'b0;
                    r_brk    <= 1'b0;
                end
            end
        end
    end

    assign ps2_key    = r_key;
    assign key_strobe = r_strobe;
    assign frame_err  = w_rx_err;

endmodule
`default_nettype wire
